mor1kx_ctrl_wb_cappuccino: RTL and testbench
============================================

// Module: mor1kx_ctrl_wb_cappuccino
// PURPOSE
//  Ctrl->writeback stage of the cappuccino pipeline, directly downstream of the execute->ctrl registers.
//  Selects the writeback result (ALU / load data / mfspr data) and registers it into the wb stage.
//  Generates the operand-forwarding hits and load/mfspr-use stall for the operands in execute.
//  Keeps a retired-instruction counter.
// PARAMETERS
//  OPTION_OPERAND_WIDTH  32  datapath width
//  OPTION_RF_ADDR_WIDTH  5   register-file address width
//  OPTION_RESET_PC       {{19{1'b0}},`OR1K_RESET_VECTOR,8'd0}  reset value of pc_wb_o
//  INSTRET_WIDTH         64  retired-instruction counter width (>=1)
// PORTS
//  clk               in   1    clock
//  rst               in   1    reset: synchronous, active-high
//  padv_ctrl_i       in   1    ctrl stage advances
//  pipeline_flush_i  in   1    kill ctrl->wb transfer
//  ctrl_bubble_i     in   1    ctrl stage holds a nop bubble
//  ctrl_rf_wb_i      in   1    ctrl instr writes RF
//  ctrl_rfd_adr_i    in   RFA  ctrl destination register
//  ctrl_op_lsu_load_i in  1    ctrl instr is a load
//  ctrl_op_mfspr_i   in   1    ctrl instr is mfspr
//  lsu_valid_i       in   1    load data valid this cycle
//  ctrl_mfspr_ack_i  in   1    mfspr data valid this cycle
//  ctrl_alu_result_i in   OW   ALU/jal result from ctrl
//  lsu_result_i      in   OW   load data
//  mfspr_dat_i       in   OW   SPR read data
//  pc_ctrl_i         in   OW   PC of ctrl instr
//  exec_rfa_adr_i    in   RFA  execute operand A address
//  exec_rfb_adr_i    in   RFA  execute operand B address
//  instret_we_i      in   1    load counter (mtspr)
//  instret_dat_i     in   IW   counter load value
//  wb_rf_wb_o        out  1    RF write enable (wb)
//  wb_rfd_adr_o      out  RFA  RF write address
//  wb_result_o       out  OW   RF write data
//  pc_wb_o           out  OW   PC of retired instr
//  wb_valid_o        out  1    one-cycle pulse per retired instr
//  fwd_ctrl_a_o/b_o  out  1    forward ctrl_alu_result_i to operand A/B
//  fwd_wb_a_o/b_o    out  1    forward wb_result_o to operand A/B
//  use_stall_o       out  1    operand depends on unfinished load/mfspr
//  instret_o         out  IW   retired-instruction count
// BEHAVIOUR
//  Reset: wb_rf_wb_o=0, wb_rfd_adr_o=0, wb_result_o=0, pc_wb_o=OPTION_RESET_PC, wb_valid_o=0, instret_o=0.
//  done = ctrl_op_lsu_load_i ? lsu_valid_i : ctrl_op_mfspr_i ? ctrl_mfspr_ack_i : padv_ctrl_i.
//  Result mux: load -> lsu_result_i, else mfspr -> mfspr_dat_i, else ctrl_alu_result_i.
//  Capture on done: wb_result_o, wb_rfd_adr_o <= mux/ctrl_rfd_adr_i; wb_rf_wb_o <= ctrl_rf_wb_i & (adr!=0).
//    Latency 1 cycle. !done -> wb_rf_wb_o<=0, data/adr hold.
//  done is evaluated once per instr: a load/mfspr sets wb_rf_wb_o exactly once, even when padv_ctrl_i comes later.
//    The ctrl stage has already cleared ctrl_rf_wb_i by then.
//  pipeline_flush_i (below rst, above capture) -> wb_rf_wb_o<=0, wb_valid_o<=0; data regs don't care.
//  wb_valid_o <= padv_ctrl_i & !ctrl_bubble_i & !pipeline_flush_i; pc_wb_o <= pc_ctrl_i on the same condition.
//  instret_o: instret_we_i loads instret_dat_i (wins over increment, no +1 that cycle).
//    Otherwise +1 on each cycle wb_valid_o is asserted (registered view, so counts lag 1 cycle).
//    Wraps at all-ones -> 0.
//  Forwarding (combinational), for X in {a,b}, addr!=0:
//    pend = (ctrl_op_lsu_load_i|ctrl_op_mfspr_i) & !done
//    fwd_ctrl_X = ctrl_rf_wb_i & ctrl_rfd_adr_i==exec_rfX_adr_i & !pend
//    fwd_wb_X = wb_rf_wb_o & wb_rfd_adr_o==exec_rfX_adr_i & !fwd_ctrl_X (ctrl has priority)
//    use_stall_o = OR over X of ctrl_rf_wb_i & adr match & pend
//  Register r0 never forwards nor stalls. Reset mid-load discards the pending result.
// TESTING
//  ALU: r3 result 0x1234, padv_ctrl_i=1 -> next cycle wb_rf_wb_o=1, adr=3, result=0x1234, wb_valid_o=1, instret +1 after.
//  Load to r5, lsu_valid_i 3 cycles late with 0xCAFE0000 -> use_stall_o=1 while exec reads r5.
//    wb_rf_wb_o pulses once, 1 cycle after lsu_valid_i, result 0xCAFE0000.
//  Write to r0 with padv -> wb_rf_wb_o stays 0, fwd_* stay 0, wb_valid_o=1.
//  Ctrl writes r7, wb holds r7 -> fwd_ctrl_a_o=1, fwd_wb_a_o=0; after ctrl moves on -> fwd_wb_a_o=1.
//  Flush coincident with padv -> wb_rf_wb_o=0, wb_valid_o=0, instret unchanged.
//  instret=all-ones + retire -> 0. instret_we_i with 0x10 and same-cycle retire -> 0x10.

Source files
------------

// File: rtl/mor1kx_ctrl_wb_cappuccino.sv
`default_nettype none
// ============================================================================
//  Module   : mor1kx_ctrl_wb_cappuccino
//  Purpose  : Ctrl->writeback stage of the cappuccino pipeline. Selects the
//             writeback result (ALU / load / mfspr), registers it into the
//             wb stage, generates operand forwarding hits and the
//             load/mfspr-use stall for execute, and keeps a retired
//             instruction counter.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             padv/flush/bubble         - ctrl stage pipeline control
//             ctrl_*                    - instruction currently in ctrl
//             lsu_*/mfspr_*             - late result sources
//             exec_rf{a,b}_adr_i        - operand addresses in execute
//             instret_we_i/dat_i        - counter load (mtspr)
//             wb_*/pc_wb_o              - registered writeback stage
//             fwd_*/use_stall_o         - combinational hazard outputs
//             instret_o                 - retired instruction count
//  Revision : 1.0 - initial release
// ============================================================================
module mor1kx_ctrl_wb_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    // Default reset vector 0x01 placed at bits [12:8]
    parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC =
        OPTION_OPERAND_WIDTH'(32'h0000_0100),
    parameter int INSTRET_WIDTH        = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_ctrl_i,
    input  logic                            pipeline_flush_i,
    input  logic                            ctrl_bubble_i,
    input  logic                            ctrl_rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] ctrl_rfd_adr_i,
    input  logic                            ctrl_op_lsu_load_i,
    input  logic                            ctrl_op_mfspr_i,
    input  logic                            lsu_valid_i,
    input  logic                            ctrl_mfspr_ack_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] mfspr_dat_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pc_ctrl_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfa_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfb_adr_i,
    input  logic                            instret_we_i,
    input  logic [INSTRET_WIDTH-1:0]        instret_dat_i,
    output logic                            wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] pc_wb_o,
    output logic                            wb_valid_o,
    output logic                            fwd_ctrl_a_o,
    output logic                            fwd_ctrl_b_o,
    output logic                            fwd_wb_a_o,
    output logic                            fwd_wb_b_o,
    output logic                            use_stall_o,
    output logic [INSTRET_WIDTH-1:0]        instret_o
);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                            wb_rf_wb_q,   wb_rf_wb_d;
    logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_q, wb_rfd_adr_d;
    logic [OPTION_OPERAND_WIDTH-1:0] wb_result_q,  wb_result_d;
    logic [OPTION_OPERAND_WIDTH-1:0] pc_wb_q,      pc_wb_d;
    logic                            wb_valid_q,   wb_valid_d;
    logic [INSTRET_WIDTH-1:0]        instret_q,    instret_d;

    // ------------------------------------------------------------------
    // Completion and result selection
    // ------------------------------------------------------------------
    logic                            w_done;
    logic                            w_pend;
    logic [OPTION_OPERAND_WIDTH-1:0] w_result;
    logic                            w_retire;

    // A load or mfspr is finished only when its data source responds;
    // everything else is finished when ctrl advances.
    assign w_done = ctrl_op_lsu_load_i ? lsu_valid_i      :
                    ctrl_op_mfspr_i    ? ctrl_mfspr_ack_i :
                                         padv_ctrl_i;

    assign w_pend = (ctrl_op_lsu_load_i | ctrl_op_mfspr_i) & ~w_done;

    assign w_result = ctrl_op_lsu_load_i ? lsu_result_i :
                      ctrl_op_mfspr_i    ? mfspr_dat_i  :
                                           ctrl_alu_result_i;

    assign w_retire = padv_ctrl_i & ~ctrl_bubble_i & ~pipeline_flush_i;

    always_comb begin
        wb_rf_wb_d   = 1'b0;
        wb_rfd_adr_d = wb_rfd_adr_q;
        wb_result_d  = wb_result_q;
        pc_wb_d      = pc_wb_q;
        wb_valid_d   = w_retire;
        instret_d    = instret_q;

        // Flush suppresses the write; data/address simply hold.
        if (!pipeline_flush_i && w_done) begin
            wb_result_d  = w_result;
            wb_rfd_adr_d = ctrl_rfd_adr_i;
            wb_rf_wb_d   = ctrl_rf_wb_i & (ctrl_rfd_adr_i != '0);
        end

        if (w_retire) begin
            pc_wb_d = pc_ctrl_i;
        end

        // Software load beats the increment; counting follows the
        // registered retire pulse so it lags retirement by one cycle.
        if (instret_we_i) begin
            instret_d = instret_dat_i;
        end else if (wb_valid_q) begin
            instret_d = instret_q + INSTRET_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rf_wb_q   <= 1'b0;
            wb_rfd_adr_q <= '0;
            wb_result_q  <= '0;
            pc_wb_q      <= OPTION_RESET_PC;
            wb_valid_q   <= 1'b0;
            instret_q    <= '0;
        end else begin
            wb_rf_wb_q   <= wb_rf_wb_d;
            wb_rfd_adr_q <= wb_rfd_adr_d;
            wb_result_q  <= wb_result_d;
            pc_wb_q      <= pc_wb_d;
            wb_valid_q   <= wb_valid_d;
            instret_q    <= instret_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding / use stall (r0 never participates)
    // ------------------------------------------------------------------
    logic w_ctrl_hit_a, w_ctrl_hit_b;
    logic w_wb_hit_a,   w_wb_hit_b;

    assign w_ctrl_hit_a = ctrl_rf_wb_i & (exec_rfa_adr_i != '0) &
                          (ctrl_rfd_adr_i == exec_rfa_adr_i);
    assign w_ctrl_hit_b = ctrl_rf_wb_i & (exec_rfb_adr_i != '0) &
                          (ctrl_rfd_adr_i == exec_rfb_adr_i);
    assign w_wb_hit_a   = wb_rf_wb_q & (exec_rfa_adr_i != '0) &
                          (wb_rfd_adr_q == exec_rfa_adr_i);
    assign w_wb_hit_b   = wb_rf_wb_q & (exec_rfb_adr_i != '0) &
                          (wb_rfd_adr_q == exec_rfb_adr_i);

    // The younger ctrl result shadows the older wb result.
    assign fwd_ctrl_a_o = w_ctrl_hit_a & ~w_pend;
    assign fwd_ctrl_b_o = w_ctrl_hit_b & ~w_pend;
    assign fwd_wb_a_o   = w_wb_hit_a & ~fwd_ctrl_a_o;
    assign fwd_wb_b_o   = w_wb_hit_b & ~fwd_ctrl_b_o;
    assign use_stall_o  = (w_ctrl_hit_a | w_ctrl_hit_b) & w_pend;

    assign wb_rf_wb_o   = wb_rf_wb_q;
    assign wb_rfd_adr_o = wb_rfd_adr_q;
    assign wb_result_o  = wb_result_q;
    assign pc_wb_o      = pc_wb_q;
    assign wb_valid_o   = wb_valid_q;
    assign instret_o    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_ctrl_wb_cappuccino.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mor1kx_ctrl_wb_cappuccino
//  Purpose  : Randomized scoreboard bench for mor1kx_ctrl_wb_cappuccino.
//             A driver issues random ctrl-stage traffic, predicts the
//             response from a behavioural model and queues it; a monitor
//             pops each prediction and compares it with the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mor1kx_ctrl_wb_cappuccino;

    localparam int  c_ncyc     = 3000;
    localparam logic [31:0] c_reset_pc = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        padv_ctrl_i, pipeline_flush_i, ctrl_bubble_i, ctrl_rf_wb_i;
    logic [4:0]  ctrl_rfd_adr_i;
    logic        ctrl_op_lsu_load_i, ctrl_op_mfspr_i, lsu_valid_i, ctrl_mfspr_ack_i;
    logic [31:0] ctrl_alu_result_i, lsu_result_i, mfspr_dat_i, pc_ctrl_i;
    logic [4:0]  exec_rfa_adr_i, exec_rfb_adr_i;
    logic        instret_we_i;
    logic [63:0] instret_dat_i;
    logic        wb_rf_wb_o;
    logic [4:0]  wb_rfd_adr_o;
    logic [31:0] wb_result_o, pc_wb_o;
    logic        wb_valid_o, fwd_ctrl_a_o, fwd_ctrl_b_o, fwd_wb_a_o, fwd_wb_b_o, use_stall_o;
    logic [63:0] instret_o;

    always #5 clk = ~clk;

    mor1kx_ctrl_wb_cappuccino dut (
        .clk(clk), .rst(rst),
        .padv_ctrl_i(padv_ctrl_i), .pipeline_flush_i(pipeline_flush_i),
        .ctrl_bubble_i(ctrl_bubble_i), .ctrl_rf_wb_i(ctrl_rf_wb_i),
        .ctrl_rfd_adr_i(ctrl_rfd_adr_i), .ctrl_op_lsu_load_i(ctrl_op_lsu_load_i),
        .ctrl_op_mfspr_i(ctrl_op_mfspr_i), .lsu_valid_i(lsu_valid_i),
        .ctrl_mfspr_ack_i(ctrl_mfspr_ack_i), .ctrl_alu_result_i(ctrl_alu_result_i),
        .lsu_result_i(lsu_result_i), .mfspr_dat_i(mfspr_dat_i), .pc_ctrl_i(pc_ctrl_i),
        .exec_rfa_adr_i(exec_rfa_adr_i), .exec_rfb_adr_i(exec_rfb_adr_i),
        .instret_we_i(instret_we_i), .instret_dat_i(instret_dat_i),
        .wb_rf_wb_o(wb_rf_wb_o), .wb_rfd_adr_o(wb_rfd_adr_o), .wb_result_o(wb_result_o),
        .pc_wb_o(pc_wb_o), .wb_valid_o(wb_valid_o),
        .fwd_ctrl_a_o(fwd_ctrl_a_o), .fwd_ctrl_b_o(fwd_ctrl_b_o),
        .fwd_wb_a_o(fwd_wb_a_o), .fwd_wb_b_o(fwd_wb_b_o),
        .use_stall_o(use_stall_o), .instret_o(instret_o)
    );

    typedef struct {
        bit          chk_comb;
        logic        fca, fcb, fwa, fwb, stall;
        bit          chk_data;
        logic        rf_wb;
        logic [4:0]  adr;
        logic [31:0] res, pc;
        logic        valid;
        logic [63:0] instret;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model state: what the wb stage should hold right now
    // ------------------------------------------------------------------
    bit          m_known = 0;
    logic        m_rf_wb, m_valid;
    logic [4:0]  m_adr;
    logic [31:0] m_res, m_pc;
    logic [63:0] m_instret;

    function automatic bit writes_reg(input logic [4:0] dst, input logic [4:0] src);
        return ctrl_rf_wb_i && src != 0 && dst == src;
    endfunction

    task automatic predict_and_push();
        exp_t e;
        bit   done, pend, late_op;
        late_op = ctrl_op_lsu_load_i || ctrl_op_mfspr_i;
        if (ctrl_op_lsu_load_i)   done = lsu_valid_i;
        else if (ctrl_op_mfspr_i) done = ctrl_mfspr_ack_i;
        else                      done = padv_ctrl_i;
        pend = late_op && !done;

        // Hazard outputs seen during this cycle
        e.chk_comb = m_known;
        e.fca   = writes_reg(ctrl_rfd_adr_i, exec_rfa_adr_i) && !pend;
        e.fcb   = writes_reg(ctrl_rfd_adr_i, exec_rfb_adr_i) && !pend;
        e.fwa   = m_rf_wb && exec_rfa_adr_i != 0 && m_adr == exec_rfa_adr_i && !e.fca;
        e.fwb   = m_rf_wb && exec_rfb_adr_i != 0 && m_adr == exec_rfb_adr_i && !e.fcb;
        e.stall = (writes_reg(ctrl_rfd_adr_i, exec_rfa_adr_i) ||
                   writes_reg(ctrl_rfd_adr_i, exec_rfb_adr_i)) && pend;

        // Advance the model by one clock
        if (rst) begin
            m_rf_wb = 0; m_adr = 0; m_res = 0; m_pc = c_reset_pc;
            m_valid = 0; m_instret = 0;
            e.chk_data = 1;
        end else begin
            if (instret_we_i)  m_instret = instret_dat_i;
            else if (m_valid)  m_instret = m_instret + 1;
            m_rf_wb = 0;
            if (!pipeline_flush_i && done) begin
                m_res   = ctrl_op_lsu_load_i ? lsu_result_i :
                          ctrl_op_mfspr_i    ? mfspr_dat_i  : ctrl_alu_result_i;
                m_adr   = ctrl_rfd_adr_i;
                m_rf_wb = ctrl_rf_wb_i && ctrl_rfd_adr_i != 0;
            end
            m_valid = padv_ctrl_i && !ctrl_bubble_i && !pipeline_flush_i;
            if (m_valid) m_pc = pc_ctrl_i;
            e.chk_data = m_rf_wb;
        end
        m_known = 1;
        e.rf_wb = m_rf_wb; e.adr = m_adr; e.res = m_res; e.pc = m_pc;
        e.valid = m_valid; e.instret = m_instret;
        q.push_back(e);
    endtask

    function automatic logic [63:0] pick_instret();
        case ($urandom_range(0, 3))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'hFFFF_FFFF_FFFF_FFFE;
            2:       return 64'h10;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic randomize_inputs(input bit force_rst);
        rst                = force_rst || ($urandom_range(0, 199) == 0);
        padv_ctrl_i        = $urandom_range(0, 9) < 7;
        pipeline_flush_i   = $urandom_range(0, 19) == 0;
        ctrl_bubble_i      = $urandom_range(0, 9) == 0;
        ctrl_rf_wb_i       = $urandom_range(0, 9) < 7;
        ctrl_rfd_adr_i     = 5'($urandom_range(0, 7));
        ctrl_op_lsu_load_i = $urandom_range(0, 3) == 0;
        ctrl_op_mfspr_i    = $urandom_range(0, 5) == 0;
        lsu_valid_i        = $urandom_range(0, 4) < 2;
        ctrl_mfspr_ack_i   = $urandom_range(0, 4) < 2;
        ctrl_alu_result_i  = $urandom;
        lsu_result_i       = $urandom;
        mfspr_dat_i        = $urandom;
        pc_ctrl_i          = $urandom & 32'hFFFF_FFFC;
        exec_rfa_adr_i     = 5'($urandom_range(0, 7));
        exec_rfb_adr_i     = 5'($urandom_range(0, 7));
        instret_we_i       = $urandom_range(0, 29) == 0;
        instret_dat_i      = pick_instret();
    endtask

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    initial begin
        randomize_inputs(1'b1);
        for (int i = 0; i < c_ncyc; i++) begin
            @(negedge clk);
            randomize_inputs(i < 3);
            #1;
            predict_and_push();
        end
        // Let the monitor drain the last prediction
        for (int t = 0; t < 10 && q.size() != 0; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_comb) begin
                    chk("fwd_ctrl_a", 64'(fwd_ctrl_a_o), 64'(e.fca));
                    chk("fwd_ctrl_b", 64'(fwd_ctrl_b_o), 64'(e.fcb));
                    chk("fwd_wb_a",   64'(fwd_wb_a_o),   64'(e.fwa));
                    chk("fwd_wb_b",   64'(fwd_wb_b_o),   64'(e.fwb));
                    chk("use_stall",  64'(use_stall_o),  64'(e.stall));
                end
                @(posedge clk);
                #1;
                chk("wb_rf_wb", 64'(wb_rf_wb_o), 64'(e.rf_wb));
                chk("wb_valid", 64'(wb_valid_o), 64'(e.valid));
                chk("pc_wb",    64'(pc_wb_o),    64'(e.pc));
                chk("instret",  instret_o,       e.instret);
                if (e.chk_data) begin
                    chk("wb_rfd_adr", 64'(wb_rfd_adr_o), 64'(e.adr));
                    chk("wb_result",  64'(wb_result_o),  64'(e.res));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #((c_ncyc + 200) * 10);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
